param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Single-clock, parametrised FIFO; next generation of the team's 4-bit/8-deep FIFO.
//  Adds generic width/depth, programmable almost-full/almost-empty, fill level and
//  sticky overflow/underflow error flags. Sits between same-clock producer/consumer.
// PARAMETERS
//  DATA_W     4   data word width in bits
//  DEPTH      8   number of entries; power of 2, >= 4
//  AF_THRESH  6   almost_full asserted when fill_count >= AF_THRESH (1..DEPTH-1)
//  AE_THRESH  2   almost_empty asserted when fill_count <= AE_THRESH (1..DEPTH-1)
// PORTS
//  i_clk         in   1                 single clock, rising edge
//  i_rst         in   1                 asynchronous reset, active-high
//  i_wen         in   1                 write request
//  data_in       in   DATA_W            write data
//  full_flag     out  1                 FIFO full
//  almost_full   out  1                 fill_count >= AF_THRESH
//  i_ren         in   1                 read request
//  data_out      out  DATA_W            read data
//  empty_flag    out  1                 FIFO empty
//  almost_empty  out  1                 fill_count <= AE_THRESH
//  fill_count    out  $clog2(DEPTH)+1   number of stored words, 0..DEPTH
//  overflow      out  1                 sticky: write attempted while full
//  underflow     out  1                 sticky: read attempted while empty
//  i_clr_err     in   1                 synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset (async assert, sync to i_clk on release): wr/rd pointers=0, fill_count=0,
//    empty_flag=1, almost_empty=1, full_flag=0, almost_full=0, data_out=0,
//    overflow=0, underflow=0. Storage array is not reset.
//  - Pointers are $clog2(DEPTH)+1 bits; low bits address, MSB is wrap bit; natural
//    binary wrap from DEPTH-1 to 0.
//  - Write accepted: i_wen & ~full_flag. Read accepted: i_ren & ~empty_flag.
//    Accept decisions use the flags registered at the current edge.
//  - Both accepted same cycle: count unchanged, both pointers advance.
//  - Full + i_wen + i_ren: only read accepted; count -> DEPTH-1. Empty + both:
//    only write accepted; count -> 1.
//  - fill_count, full_flag, empty_flag, almost_* all registered; they reflect the
//    accepted operations of the previous edge (valid the cycle after the edge).
//  - Default mode: data_out registered; read latency 1 (word at head appears on
//    data_out one cycle after the accepting edge); holds its value otherwise.
//  - Rejected write while full sets overflow; rejected read while empty sets
//    underflow. Flags stay high until i_clr_err; if set and clear coincide, set wins.
//  - Rejected ops change no pointer, count or data_out.
//  - Reset asserted mid-operation discards all contents immediately.
// CONFIGURATION
//  FWFT_EN defined: first-word-fall-through. data_out driven combinationally from
//    the head entry; valid whenever empty_flag=0; i_ren acknowledges/pops head,
//    next word visible same cycle after the edge. Latency 0; data_out is X/stale
//    while empty.
//  FWFT_EN undefined: standard registered-read mode described above.
// TESTING
//  1 Reset: assert i_rst 3 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0.
//  2 Write 0..7 (DEPTH=8) -> count 1..8; almost_full at count 6; full_flag at 8;
//    9th write 0x8 rejected, overflow=1, count stays 8.
//  3 Read 8 words -> data_out 0..7 in order (1-cycle latency); almost_empty at
//    count 2; empty at 0; extra read sets underflow=1; i_clr_err clears both.
//  4 Simultaneous wr+rd at count 4 for 20 cycles -> count stays 4, data in order,
//    pointers wrap past 7 with no corruption.
//  5 Full + wen + ren -> read only, count 7, overflow set; empty + wen + ren ->
//    write only, count 1, underflow set.
//  6 FWFT_EN build: single write 0xA into empty FIFO -> next cycle empty=0,
//    data_out=0xA with no i_ren; one i_ren -> empty=1.

Source files
------------

// File: rtl/param_sync_fifo_if.sv
// Handshake/data bundle for param_sync_fifo: producer write side, consumer read side,
// status flags and sticky error flags.
interface param_sync_fifo_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
);
  logic                       i_wen;
  logic [DATA_W-1:0]          data_in;
  logic                       full_flag;
  logic                       almost_full;
  logic                       i_ren;
  logic [DATA_W-1:0]          data_out;
  logic                       empty_flag;
  logic                       almost_empty;
  logic [$clog2(DEPTH):0]     fill_count;
  logic                       overflow;
  logic                       underflow;
  logic                       i_clr_err;

  modport master (
    output i_wen, data_in, i_ren, i_clr_err,
    input  full_flag, almost_full, data_out, empty_flag, almost_empty,
           fill_count, overflow, underflow
  );

  modport slave (
    input  i_wen, data_in, i_ren, i_clr_err,
    output full_flag, almost_full, data_out, empty_flag, almost_empty,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with registered status, fill level and sticky errors.
// Define FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module param_sync_fifo #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  param_sync_fifo_if.slave  fifo_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_acc, rd_acc;

  // Accept decisions come from the flags registered at this edge; the count falls
  // out of the wrap-bit pointer difference, so simultaneous ops cancel naturally.
  always_comb begin
    wr_acc   = fifo_if.i_wen & ~full_q;
    rd_acc   = fifo_if.i_ren & ~empty_q;
    wr_ptr_d = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d = rd_ptr_q + CW'(rd_acc);
    count_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = (fifo_if.i_wen & full_q)  | (ovf_q & ~fifo_if.i_clr_err);
    unf_d    = (fifo_if.i_ren & empty_q) | (unf_q & ~fifo_if.i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= CW'(AF_THRESH));
      ae_q     <= (count_d <= CW'(AE_THRESH));
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= fifo_if.data_in;
    end
  end

`ifdef FWFT_EN
  assign fifo_if.data_out = mem[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign fifo_if.data_out = dout_q;
`endif

  assign fifo_if.fill_count   = count_q;
  assign fifo_if.full_flag    = full_q;
  assign fifo_if.empty_flag   = empty_q;
  assign fifo_if.almost_full  = af_q;
  assign fifo_if.almost_empty = ae_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DEPTH=8, DATA_W=4) with a data scoreboard
// and a reference fill/flag model; handles both default and FWFT_EN builds.
module tb_param_sync_fifo;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic rst;

  param_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .fifo_if(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb_q[$];
  int   m_count;
  logic m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"},  32'(bus.fill_count),   32'(m_count));
    chk({tag, ".full"},   32'(bus.full_flag),    32'(m_count == DEPTH));
    chk({tag, ".empty"},  32'(bus.empty_flag),   32'(m_count == 0));
    chk({tag, ".afull"},  32'(bus.almost_full),  32'(m_count >= AF));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(m_count <= AE));
    chk({tag, ".ovf"},    32'(bus.overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(bus.underflow),    32'(m_unf));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of stimulus: drive after the falling edge, check 1 time unit after the rising edge.
  task automatic step(input logic wen, input logic [DATA_W-1:0] din,
                      input logic ren, input logic clr, input string tag);
    logic wacc, racc;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    bus.i_wen     = wen;
    bus.data_in   = din;
    bus.i_ren     = ren;
    bus.i_clr_err = clr;
    wacc = wen && (m_count < DEPTH);
    racc = ren && (m_count > 0);
`ifdef FWFT_EN
    #1;
    if (racc) chk({tag, ".fwft_head"}, 32'(bus.data_out), 32'(sb_q[0]));
`endif
    @(posedge clk);
    #1;
    if (racc) begin
      exp_d = sb_q.pop_front();
`ifndef FWFT_EN
      chk({tag, ".dout"}, 32'(bus.data_out), 32'(exp_d));
`endif
    end
    if (wacc) sb_q.push_back(din);
    m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
    m_ovf   = (wen && !wacc) || (m_ovf && !clr);
    m_unf   = (ren && !racc) || (m_unf && !clr);
    chk_status(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v;
    bus.i_wen = 1'b0; bus.data_in = '0; bus.i_ren = 1'b0; bus.i_clr_err = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset");
`ifndef FWFT_EN
    chk("reset.dout", 32'(bus.data_out), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Fill 0..7, then a rejected 9th write raises overflow
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, "fill");
    // Drain all, then a rejected extra read raises underflow
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
    step(1'b0, '0, 1'b0, 1'b1, "clr");

    // Steady simultaneous traffic at count 4 wraps the pointers several times
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(9 + i), 1'b0, 1'b0, "pre4");
    for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(13 + i), 1'b1, 1'b0, "rw4");

    // Full + write + read: only the read is taken
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'($urandom_range(0, 15)), 1'b0, 1'b0, "top");
    step(1'b1, 4'h3, 1'b1, 1'b0, "fullrw");
    step(1'b0, '0, 1'b0, 1'b1, "clr2");
    // Empty + write + read: only the write is taken
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0, "drain2");
    step(1'b1, 4'h5, 1'b1, 1'b0, "emptyrw");
    step(1'b0, '0, 1'b1, 1'b0, "last");
    step(1'b0, '0, 1'b0, 1'b1, "clr3");

    // Set and clear in the same cycle: set wins
    step(1'b0, '0, 1'b1, 1'b1, "setwins");
    step(1'b0, '0, 1'b0, 1'b1, "clr4");

    // Single word into an empty FIFO, then pop it
    step(1'b1, 4'hA, 1'b0, 1'b0, "single");
`ifdef FWFT_EN
    chk("single.fwft_visible", 32'(bus.data_out), 32'hA);
`endif
    step(1'b0, '0, 1'b1, 1'b0, "single_rd");

    // Asynchronous reset mid-operation discards contents immediately
    for (int i = 0; i < 3; i++) begin
      v = DATA_W'($urandom_range(0, 15));
      step(1'b1, v, 1'b0, 1'b0, "prerst");
    end
    @(negedge clk);
    bus.i_wen = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_status("asyncrst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'h7, 1'b0, 1'b0, "postrst_wr");
    step(1'b0, '0, 1'b1, 1'b0, "postrst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
